// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_W = 64;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving instruction fetch and load/store exclusive use of
// one single-port 64-bit memory; one access in flight, LATENCY read cycles.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             if_req,
    input  logic [MEM_W-1:0] if_addr,
    output logic             if_gnt,
    output logic [31:0]      if_rdata,
    output logic             if_valid,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [MEM_W-1:0] d_addr,
    input  logic [MEM_W-1:0] d_wdata,
    output logic             d_gnt,
    output logic [MEM_W-1:0] d_rdata,
    output logic             d_valid,

    output logic [MEM_W-1:0] mem_addr,
    output logic [MEM_W-1:0] mem_wdata,
    output logic             mem_wr,
    input  logic [MEM_W-1:0] mem_rdata
);

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    arb_state_t state, stateNext;
    arb_owner_t lastOwner, owner;
    logic [2:0] latCnt;
    logic       accWe;
    logic       pickIf, pickD, grant;

    // Tie goes to whichever port was not served last.
    assign pickIf = if_req && (!d_req || lastOwner == OWN_D);
    assign pickD  = d_req && !pickIf;
    // Gated by reset so no grant leaks out while the block is held in reset.
    assign grant  = reset && (state == IDLE) && (if_req || d_req);

    assign if_gnt   = grant && pickIf;
    assign d_gnt    = grant && pickD;
    assign if_valid = (state == RESP) && (owner == OWN_IF);
    assign d_valid  = (state == RESP) && (owner == OWN_D);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grant) stateNext = BUSY;
            BUSY:    if (latCnt == 3'd0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lastOwner <= OWN_D;
            owner     <= OWN_IF;
            latCnt    <= '0;
            accWe     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state  <= stateNext;
            mem_wr <= 1'b0;
            if (grant) begin
                latCnt    <= CNT_INIT;
                lastOwner <= pickIf ? OWN_IF : OWN_D;
                owner     <= pickIf ? OWN_IF : OWN_D;
                if (pickIf) begin
                    mem_addr <= if_addr;
                    accWe    <= 1'b0;
                end else begin
                    // Data accesses are always whole 64-bit words.
                    mem_addr  <= d_addr & ~64'h7;
                    mem_wdata <= d_wdata;
                    accWe     <= d_we;
                    mem_wr    <= d_we;
                end
            end else if (state == BUSY) begin
                if (latCnt != 3'd0) begin
                    latCnt <= latCnt - 3'd1;
                end else if (!accWe) begin
                    if (owner == OWN_IF)
                        if_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    else
                        d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LATENCY = 2 with a behavioural memory.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_gnt;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memoria64-style memory: combinational read, write on the clock edge.
    logic [63:0] mem [0:255];
    logic        memLoaded = 1'b0;
    assign mem_rdata = mem[mem_addr[10:3]];
    always @(posedge clock) begin
        if (!memLoaded) begin
            for (int k = 0; k < 256; k++) mem[k] <= 64'h0;
            mem[32]   <= 64'hAAAA_BBBB_1111_2222;
            memLoaded <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr[10:3]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        ifReq;
        logic [63:0] ifAddr;
        logic        dReq;
        logic        dWe;
        logic [63:0] dAddr;
        logic [63:0] dWdata;
        logic        eIfGnt;
        logic        eDGnt;
        logic        eIfValid;
        logic        eDValid;
        logic        eMemWr;
        logic [63:0] eMemAddr;
        logic [63:0] eMemWdata;
        logic [31:0] eIfRdata;
        logic [63:0] eDRdata;
    } vec_t;

    vec_t vecs [0:24];

    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
                                input logic [63:0] da, input logic [63:0] dd,
                                input logic ig, input logic dg, input logic iv, input logic dv,
                                input logic mw, input logic [63:0] ma, input logic [63:0] md,
                                input logic [31:0] ird, input logic [63:0] drd);
        vec_t v;
        v.ifReq = ir; v.ifAddr = ia; v.dReq = dr; v.dWe = dw; v.dAddr = da; v.dWdata = dd;
        v.eIfGnt = ig; v.eDGnt = dg; v.eIfValid = iv; v.eDValid = dv; v.eMemWr = mw;
        v.eMemAddr = ma; v.eMemWdata = md; v.eIfRdata = ird; v.eDRdata = drd;
        return v;
    endfunction

    localparam logic [63:0] SD = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] MW = 64'hAAAA_BBBB_1111_2222;

    initial begin
        // Fetch 0x104, data store requested during fetch BUSY, then load, then contention.
        //            ifReq ifAddr  dReq dWe dAddr   dWdata  iG dG iV dV mWr memAddr  memWdata ifRdata       dRdata
        vecs[0]  = mk(1, 64'h104, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 0, 64'h0,   64'h0, 32'h0,         64'h0);
        vecs[1]  = mk(0, 64'h104, 1, 1, 64'h40, SD,    0, 0, 0, 0, 0, 64'h104, 64'h0, 32'h0,         64'h0);
        vecs[2]  = mk(0, 64'h104, 1, 1, 64'h40, SD,    0, 0, 0, 0, 0, 64'h104, 64'h0, 32'h0,         64'h0);
        vecs[3]  = mk(0, 64'h104, 1, 1, 64'h40, SD,    0, 0, 1, 0, 0, 64'h104, 64'h0, 32'hAAAA_BBBB, 64'h0);
        vecs[4]  = mk(0, 64'h104, 1, 1, 64'h40, SD,    0, 1, 0, 0, 0, 64'h104, 64'h0, 32'hAAAA_BBBB, 64'h0);
        vecs[5]  = mk(0, 64'h104, 0, 0, 64'h40, SD,    0, 0, 0, 0, 1, 64'h40,  SD,    32'hAAAA_BBBB, 64'h0);
        vecs[6]  = mk(0, 64'h104, 0, 0, 64'h40, SD,    0, 0, 0, 0, 0, 64'h40,  SD,    32'hAAAA_BBBB, 64'h0);
        vecs[7]  = mk(0, 64'h104, 0, 0, 64'h40, SD,    0, 0, 0, 1, 0, 64'h40,  SD,    32'hAAAA_BBBB, 64'h0);
        vecs[8]  = mk(0, 64'h104, 1, 0, 64'h47, SD,    0, 1, 0, 0, 0, 64'h40,  SD,    32'hAAAA_BBBB, 64'h0);
        vecs[9]  = mk(0, 64'h104, 0, 0, 64'h47, SD,    0, 0, 0, 0, 0, 64'h40,  SD,    32'hAAAA_BBBB, 64'h0);
        vecs[10] = mk(0, 64'h104, 0, 0, 64'h47, SD,    0, 0, 0, 0, 0, 64'h40,  SD,    32'hAAAA_BBBB, 64'h0);
        vecs[11] = mk(0, 64'h104, 0, 0, 64'h47, SD,    0, 0, 0, 1, 0, 64'h40,  SD,    32'hAAAA_BBBB, SD);
        vecs[12] = mk(1, 64'h100, 1, 0, 64'h100, SD,   1, 0, 0, 0, 0, 64'h40,  SD,    32'hAAAA_BBBB, SD);
        vecs[13] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 0, 0, 0, 64'h100, SD,    32'hAAAA_BBBB, SD);
        vecs[14] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 0, 0, 0, 64'h100, SD,    32'hAAAA_BBBB, SD);
        vecs[15] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 1, 0, 0, 64'h100, SD,    32'h1111_2222, SD);
        vecs[16] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 1, 0, 0, 0, 64'h100, SD,    32'h1111_2222, SD);
        vecs[17] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 0, 0, 0, 64'h100, SD,    32'h1111_2222, SD);
        vecs[18] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 0, 0, 0, 64'h100, SD,    32'h1111_2222, SD);
        vecs[19] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 0, 1, 0, 64'h100, SD,    32'h1111_2222, MW);
        vecs[20] = mk(1, 64'h100, 1, 0, 64'h100, SD,   1, 0, 0, 0, 0, 64'h100, SD,    32'h1111_2222, MW);
        vecs[21] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 0, 0, 0, 64'h100, SD,    32'h1111_2222, MW);
        vecs[22] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 0, 0, 0, 64'h100, SD,    32'h1111_2222, MW);
        vecs[23] = mk(1, 64'h100, 1, 0, 64'h100, SD,   0, 0, 1, 0, 0, 64'h100, SD,    32'h1111_2222, MW);
        vecs[24] = mk(0, 64'h100, 0, 0, 64'h100, SD,   0, 0, 0, 0, 0, 64'h100, SD,    32'h1111_2222, MW);

        // Reset held 3 cycles with both requests high: everything stays 0.
        if_req = 1'b1; d_req = 1'b1; if_addr = 64'h104; d_addr = 64'h40; d_wdata = SD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("rst_if_gnt", c, 64'(if_gnt), 64'h0);
            chk("rst_d_gnt", c, 64'(d_gnt), 64'h0);
            chk("rst_valids", c, 64'({if_valid, d_valid, mem_wr}), 64'h0);
            chk("rst_mem_addr", c, mem_addr, 64'h0);
            chk("rst_mem_wdata", c, mem_wdata, 64'h0);
            chk("rst_rdata", c, d_rdata | 64'(if_rdata), 64'h0);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("first_tie_if_gnt", 0, 64'(if_gnt), 64'h1);
        chk("first_tie_d_gnt", 0, 64'(d_gnt), 64'h0);
        // Clean restart for the vector table.
        @(posedge clock); #1;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i <= 24; i++) begin
            if_req = vecs[i].ifReq; if_addr = vecs[i].ifAddr;
            d_req = vecs[i].dReq; d_we = vecs[i].dWe; d_addr = vecs[i].dAddr; d_wdata = vecs[i].dWdata;
            @(negedge clock);
            chk("if_gnt", i, 64'(if_gnt), 64'(vecs[i].eIfGnt));
            chk("d_gnt", i, 64'(d_gnt), 64'(vecs[i].eDGnt));
            chk("if_valid", i, 64'(if_valid), 64'(vecs[i].eIfValid));
            chk("d_valid", i, 64'(d_valid), 64'(vecs[i].eDValid));
            chk("mem_wr", i, 64'(mem_wr), 64'(vecs[i].eMemWr));
            chk("mem_addr", i, mem_addr, vecs[i].eMemAddr);
            chk("mem_wdata", i, mem_wdata, vecs[i].eMemWdata);
            chk("if_rdata", i, 64'(if_rdata), 64'(vecs[i].eIfRdata));
            chk("d_rdata", i, d_rdata, vecs[i].eDRdata);
            @(posedge clock); #1;
        end

        // Reset in the first BUSY cycle of a store: write strobe drops at once, no valid.
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'hDEAD_BEEF_0000_1234;
        @(negedge clock);
        chk("mid_d_gnt", 0, 64'(d_gnt), 64'h1);
        @(posedge clock); #1;
        d_req = 1'b0;
        chk("mid_mem_wr_before", 1, 64'(mem_wr), 64'h1);
        reset = 1'b0;
        #1;
        chk("mid_mem_wr_drop", 1, 64'(mem_wr), 64'h0);
        chk("mid_mem_addr_clr", 1, mem_addr, 64'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("mid_no_d_valid", c, 64'(d_valid), 64'h0);
            @(posedge clock); #1;
        end
        // Still IDLE: a fresh fetch is granted immediately.
        if_req = 1'b1; if_addr = 64'h100;
        @(negedge clock);
        chk("mid_idle_if_gnt", 0, 64'(if_gnt), 64'h1);
        @(posedge clock); #1;
        if_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
